// File: rtl/param_adder_pkg.sv
// Shared constants for the segmented pipelined adder: default geometry,
// the add/subtract mode encoding and signed saturation limits.
package param_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_SEGS  = 2;

    // Encoding of the i_sub control input.
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } add_mode_e;

    // Signed limits at the default width (0111..1 and 1000..0).
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_SMAX = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_SMIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/adder_seg.sv
// One SEG_W-bit ripple-carry segment. Purely combinational; the enclosing
// pipeline registers its carry-out. The carry into the top bit is exposed so
// the last segment can form the signed overflow flag.
module adder_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [SEG_W:0] carry;
    genvar gi;

    assign carry[0] = cin;

    generate
        for (gi = 0; gi < SEG_W; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout    = carry[SEG_W];
    assign msb_cin = carry[SEG_W-1];

endmodule

// File: rtl/param_pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor split into SEGS carry-registered
// segments with a valid/ready handshake. Stage k adds segment k of operands
// that travel down the pipe with it, so results never mix operations.
// Optional macro PARAM_ADDER_SAT_EN: saturate the result on signed overflow.
import param_adder_pkg::*;

module param_pipe_adder #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEGS  = DEFAULT_SEGS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int SEG_W = WIDTH / SEGS;

`ifdef PARAM_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage registers: stage k holds the operation after segment k was added.
    logic             v_reg [SEGS];
    logic             c_reg [SEGS];
    logic [WIDTH-1:0] a_reg [SEGS];
    logic [WIDTH-1:0] b_reg [SEGS];
    logic [WIDTH-1:0] r_reg [SEGS];
    logic             ov_reg;

    // Inputs seen by each stage's segment adder (stage 0 from the ports).
    logic             src_v [SEGS];
    logic             src_c [SEGS];
    logic [WIDTH-1:0] src_a [SEGS];
    logic [WIDTH-1:0] src_b [SEGS];
    logic [WIDTH-1:0] src_r [SEGS];

    logic [SEG_W-1:0] seg_sum     [SEGS];
    logic             seg_cout    [SEGS];
    logic             seg_msb_cin [SEGS];

    logic [WIDTH-1:0] r_next [SEGS];
    logic             ov_next;
    logic             pipe_en;

    genvar gi;

    // Whole pipe advances together unless the output holds an unaccepted result.
    assign pipe_en = i_ready || !v_reg[SEGS-1];

    // Route each stage's operands: stage 0 from the ports (B inverted for
    // subtraction, carry-in = i_sub), later stages from the previous register.
    always_comb begin
        src_v[0] = i_valid;
        src_c[0] = i_sub;
        src_a[0] = i_add_term1;
        src_b[0] = (i_sub == MODE_SUB) ? ~i_add_term2 : i_add_term2;
        src_r[0] = '0;
        for (int k = 1; k < SEGS; k++) begin
            src_v[k] = v_reg[k-1];
            src_c[k] = c_reg[k-1];
            src_a[k] = a_reg[k-1];
            src_b[k] = b_reg[k-1];
            src_r[k] = r_reg[k-1];
        end
    end

    generate
        for (gi = 0; gi < SEGS; gi++) begin : g_seg
            adder_seg #(
                .SEG_W (SEG_W)
            ) u_seg (
                .a       (src_a[gi][gi*SEG_W +: SEG_W]),
                .b       (src_b[gi][gi*SEG_W +: SEG_W]),
                .cin     (src_c[gi]),
                .sum     (seg_sum[gi]),
                .cout    (seg_cout[gi]),
                .msb_cin (seg_msb_cin[gi])
            );
        end
    endgenerate

    // Merge each segment sum into its partial result; form overflow (and the
    // optional saturated value) in the final segment.
    always_comb begin
        for (int k = 0; k < SEGS; k++) begin
            r_next[k] = src_r[k];
            r_next[k][k*SEG_W +: SEG_W] = seg_sum[k];
        end
        ov_next = seg_msb_cin[SEGS-1] ^ seg_cout[SEGS-1];
`ifdef PARAM_ADDER_SAT_EN
        if (ov_next) begin
            r_next[SEGS-1] = src_a[SEGS-1][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // Pipeline registers: cleared asynchronously, shifted when the pipe is enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SEGS; k++) begin
                v_reg[k] <= 1'b0;
                c_reg[k] <= 1'b0;
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                r_reg[k] <= '0;
            end
            ov_reg <= 1'b0;
        end else if (pipe_en) begin
            for (int k = 0; k < SEGS; k++) begin
                v_reg[k] <= src_v[k];
                c_reg[k] <= seg_cout[k];
                a_reg[k] <= src_a[k];
                b_reg[k] <= src_b[k];
                r_reg[k] <= r_next[k];
            end
            ov_reg <= ov_next;
        end
    end

    assign o_ready    = pipe_en;
    assign o_valid    = v_reg[SEGS-1];
    assign o_result   = r_reg[SEGS-1];
    assign o_carry    = c_reg[SEGS-1];
    assign o_overflow = ov_reg;

endmodule

// File: tb/tb_param_pipe_adder.sv
// Self-checking bench for param_pipe_adder: directed vector table on an
// 8-bit/2-segment instance, stall and mid-stream reset sequences, and a
// randomised stream on a 12-bit/3-segment instance against a reference model.
module tb_param_pipe_adder;

`ifdef PARAM_ADDER_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // 8-bit, 2-segment instance
    logic       i_valid = 1'b0, i_ready = 1'b0, i_sub = 1'b0;
    logic [7:0] i_a = '0, i_b = '0;
    logic       o_ready, o_valid, o_carry, o_overflow;
    logic [7:0] o_result;

    // 12-bit, 3-segment instance
    logic        v12 = 1'b0, r12 = 1'b0, sub12 = 1'b0;
    logic [11:0] a12 = '0, b12 = '0;
    logic        ordy12, oval12, oc12, oov12;
    logic [11:0] ores12;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] r_wrap;
        logic [7:0] r_sat;
        logic       c;
        logic       ov;
    } vec_t;

    always #5 clk = ~clk;

    param_pipe_adder #(.WIDTH(8), .SEGS(2)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_a),
        .i_add_term2 (i_b),
        .i_sub       (i_sub),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_carry     (o_carry),
        .o_overflow  (o_overflow)
    );

    param_pipe_adder #(.WIDTH(12), .SEGS(3)) u_dut12 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (v12),
        .o_ready     (ordy12),
        .i_add_term1 (a12),
        .i_add_term2 (b12),
        .i_sub       (sub12),
        .o_valid     (oval12),
        .i_ready     (r12),
        .o_result    (ores12),
        .o_carry     (oc12),
        .o_overflow  (oov12)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: A + B or A + ~B + 1 at width w, with carry, signed overflow
    // from operand/result signs, and optional saturation.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [31:0] mask, bx, s;
        exp_t e;
        mask = (32'd1 << w) - 32'd1;
        bx   = sub ? (~{16'h0, b}) & mask : {16'h0, b};
        s    = {16'h0, a} + bx + {31'd0, sub};
        e.r  = 16'(s & mask);
        e.c  = s[w];
        e.ov = (a[w-1] == bx[w-1]) && (e.r[w-1] != a[w-1]);
        if (SAT_ON && e.ov) begin
            e.r = a[w-1] ? 16'(32'd1 << (w-1)) : 16'(mask >> 1);
        end
        return e;
    endfunction

    vec_t vecs[10];
    exp_t q12[$];
    exp_t exp_s[4];

    initial begin
        int in_cnt, out_cnt, extra, seen;
        bit was_stalled, saw_drop;
        logic [7:0] held_r;
        logic held_c, held_ov;
        exp_t e;

        //         a      b      sub   wrap   sat    c     ov
        vecs[0] = '{8'h01, 8'h01, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[5] = '{8'h05, 8'h03, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0};
        vecs[6] = '{8'h03, 8'h05, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1};

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid",    32'(o_valid), 32'd0);
        check("rst_result",   32'(o_result), 32'd0);
        check("rst_carry",    32'(o_carry), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_ready",    32'(o_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(o_ready), 32'd1);

        // Directed vectors, one operation at a time with i_ready high.
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            i_a     = vecs[i].a;
            i_b     = vecs[i].b;
            i_sub   = vecs[i].sub;
            tick();
            i_valid = 1'b0;
            check($sformatf("vec%0d_not_early", i), 32'(o_valid), 32'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'd1);
            check($sformatf("vec%0d_result", i), 32'(o_result),
                  32'(SAT_ON ? vecs[i].r_sat : vecs[i].r_wrap));
            check($sformatf("vec%0d_carry", i), 32'(o_carry), 32'(vecs[i].c));
            check($sformatf("vec%0d_overflow", i), 32'(o_overflow), 32'(vecs[i].ov));
            tick();
        end

        // Four back-to-back ops with the output stalled for three cycles.
        for (int i = 0; i < 4; i++) begin
            exp_s[i] = model(8, 16'(8'h10 * i + 8'h03), 16'h0021, 1'(i % 2));
        end
        in_cnt = 0; out_cnt = 0; was_stalled = 1'b0; saw_drop = 1'b0;
        held_r = '0; held_c = 1'b0; held_ov = 1'b0;
        for (int cyc = 0; cyc < 40 && out_cnt < 4; cyc++) begin
            i_ready = !(cyc >= 3 && cyc <= 5);
            if (in_cnt < 4) begin
                i_valid = 1'b1;
                i_a     = 8'(8'h10 * in_cnt + 8'h03);
                i_b     = 8'h21;
                i_sub   = 1'(in_cnt % 2);
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            if (o_valid && !i_ready) begin
                if (!o_ready) saw_drop = 1'b1;
                if (was_stalled) begin
                    check("stall_hold_result",   32'(o_result), 32'(held_r));
                    check("stall_hold_carry",    32'(o_carry), 32'(held_c));
                    check("stall_hold_overflow", 32'(o_overflow), 32'(held_ov));
                end
                held_r = o_result; held_c = o_carry; held_ov = o_overflow;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (o_valid && i_ready) begin
                check($sformatf("stream%0d_result", out_cnt), 32'(o_result), 32'(exp_s[out_cnt].r[7:0]));
                check($sformatf("stream%0d_carry", out_cnt), 32'(o_carry), 32'(exp_s[out_cnt].c));
                check($sformatf("stream%0d_overflow", out_cnt), 32'(o_overflow), 32'(exp_s[out_cnt].ov));
                out_cnt++;
            end
            if (i_valid && o_ready) in_cnt++;
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stream_in_count",  32'(in_cnt), 32'd4);
        check("stream_out_count", 32'(out_cnt), 32'd4);
        check("stream_ready_dropped", 32'(saw_drop), 32'd1);
        extra = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (o_valid) extra++;
            tick();
        end
        check("stream_no_duplicate", 32'(extra), 32'd0);

        // Reset with two operations in flight.
        i_valid = 1'b1; i_a = 8'h11; i_b = 8'h22; i_sub = 1'b0;
        tick();
        i_a = 8'h33; i_b = 8'h44;
        tick();
        i_valid = 1'b0;
        check("inflight_valid", 32'(o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid",  32'(o_valid), 32'd0);
        check("midrst_result", 32'(o_result), 32'd0);
        check("midrst_ready",  32'(o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick();
            if (o_valid) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        // Randomised stream on the 12-bit/3-segment instance.
        out_cnt = 0;
        for (int cyc = 0; cyc < 6000 && out_cnt < 300; cyc++) begin
            v12   = ($urandom_range(0, 3) != 0);
            r12   = ($urandom_range(0, 3) != 0);
            a12   = 12'($urandom_range(0, 4095));
            b12   = 12'($urandom_range(0, 4095));
            sub12 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (v12 && ordy12) q12.push_back(model(12, 16'(a12), 16'(b12), sub12));
            if (oval12 && r12) begin
                if (q12.size() == 0) begin
                    check("rand_spurious_output", 32'(oval12), 32'd0);
                end else begin
                    e = q12.pop_front();
                    check($sformatf("rand%0d", out_cnt), {18'd0, oc12, oov12, ores12},
                          {18'd0, e.c, e.ov, e.r[11:0]});
                    out_cnt++;
                end
            end
            tick();
        end
        v12 = 1'b0;
        check("rand_out_count", 32'(out_cnt), 32'd300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
